// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: arbiter states, one-hot owner codes and default widths shared with the SPI slave and memory
package spi_mem_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_SPI = 2'b01;
  localparam logic [1:0] OWN_LCL = 2'b10;
  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/spi_mem_arbiter_if.sv
// spi_mem_arbiter_if: both requester ports, the memory port and grant status of spi_mem_arbiter
interface spi_mem_arbiter_if #(
  parameter int ADDR_W = spi_mem_pkg::ADDR_W_DEF,
  parameter int DATA_W = spi_mem_pkg::DATA_W_DEF
);
  logic              spi_req, spi_we, spi_ack;
  logic [ADDR_W-1:0] spi_addr;
  logic [DATA_W-1:0] spi_wdata, spi_rdata;
  logic              lcl_req, lcl_we, lcl_ack;
  logic [ADDR_W-1:0] lcl_addr;
  logic [DATA_W-1:0] lcl_wdata, lcl_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [1:0]        owner;
  logic              busy;
  modport slave (
    input  spi_req, spi_we, spi_addr, spi_wdata, lcl_req, lcl_we, lcl_addr, lcl_wdata, mem_rdata,
    output spi_ack, spi_rdata, lcl_ack, lcl_rdata, mem_addr, mem_we, mem_wdata, owner, busy
  );
  modport master (
    output spi_req, spi_we, spi_addr, spi_wdata, lcl_req, lcl_we, lcl_addr, lcl_wdata, mem_rdata,
    input  spi_ack, spi_rdata, lcl_ack, lcl_rdata, mem_addr, mem_we, mem_wdata, owner, busy
  );
endinterface

// File: rtl/spi_mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way one-hot picker ({lcl, spi})
// SPI_FIXED_PRIORITY_EN: SPI always wins and may re-grant itself; otherwise round-robin on the last grant
module rr_pick2
  import spi_mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_lcl_i,
  input  logic [1:0] excl_i,
  output logic [1:0] gnt_o
);
  logic [1:0] r;
`ifdef SPI_FIXED_PRIORITY_EN
  assign r = {req_i[1] & ~excl_i[1], req_i[0]};
  assign gnt_o = r[0] ? OWN_SPI : r[1] ? OWN_LCL : OWN_NONE;
`else
  assign r = req_i & ~excl_i;
  assign gnt_o = (r[0] & (~r[1] | last_lcl_i)) ? OWN_SPI : r[1] ? OWN_LCL : OWN_NONE;
`endif
endmodule

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: serialises SPI-slave and local-core byte accesses onto the single-port data memory
// Build option SPI_FIXED_PRIORITY_EN gives SPI fixed priority instead of round-robin.
module spi_mem_arbiter
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = 1
) (
  input logic              clk,
  input logic              reset,
  spi_mem_arbiter_if.slave bus
);
  state_e            state_q, state_d;
  logic [1:0]        owner_q, owner_d, gnt;
  logic              last_lcl_q, last_lcl_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, spi_rdata_q, spi_rdata_d, lcl_rdata_q, lcl_rdata_d;
  logic [2:0]        cnt_q, cnt_d;

  rr_pick2 u_pick (
    .req_i      ({bus.lcl_req, bus.spi_req}),
    .last_lcl_i (last_lcl_q),
    .excl_i     (state_q == DONE ? owner_q : OWN_NONE),
    .gnt_o      (gnt)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_lcl_d  = last_lcl_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    spi_rdata_d = spi_rdata_q;
    lcl_rdata_d = lcl_rdata_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        last_lcl_d = state_q == DONE ? owner_q[1] : last_lcl_q;
        state_d    = gnt != OWN_NONE ? ISSUE : IDLE;
        owner_d    = gnt;
        we_d       = gnt[1] ? bus.lcl_we : gnt[0] ? bus.spi_we : we_q;
        addr_d     = gnt[1] ? bus.lcl_addr : gnt[0] ? bus.spi_addr : addr_q;
        wdata_d    = gnt[1] ? bus.lcl_wdata : gnt[0] ? bus.spi_wdata : wdata_q;
      end
      ISSUE: begin
        state_d = we_q ? DONE : WAIT;
        cnt_d   = 3'(MEM_LAT - 1);
      end
      WAIT: begin
        state_d     = cnt_q == '0 ? DONE : WAIT;
        cnt_d       = cnt_q - 3'd1;
        spi_rdata_d = (cnt_q == '0 && owner_q == OWN_SPI) ? bus.mem_rdata : spi_rdata_q;
        lcl_rdata_d = (cnt_q == '0 && owner_q == OWN_LCL) ? bus.mem_rdata : lcl_rdata_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      last_lcl_q  <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      spi_rdata_q <= '0;
      lcl_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_lcl_q  <= last_lcl_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      spi_rdata_q <= spi_rdata_d;
      lcl_rdata_q <= lcl_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = state_q == ISSUE && we_q;
  assign bus.spi_ack   = state_q == DONE && owner_q == OWN_SPI;
  assign bus.lcl_ack   = state_q == DONE && owner_q == OWN_LCL;
  assign bus.spi_rdata = spi_rdata_q;
  assign bus.lcl_rdata = lcl_rdata_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: directed scoreboard bench; a MEM_LAT=1 instance plus a MEM_LAT=3 instance
module tb_spi_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, failures = 0, ack_cnt = 0, we_cnt = 0;

  typedef struct {logic lcl; logic rd; logic [7:0] data;} exp_t;
  exp_t sb[$];

  spi_mem_arbiter_if #(.ADDR_W(7), .DATA_W(8)) b1 ();
  spi_mem_arbiter_if #(.ADDR_W(7), .DATA_W(8)) b3 ();
  spi_mem_arbiter #(.ADDR_W(7), .DATA_W(8), .MEM_LAT(1)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
  spi_mem_arbiter #(.ADDR_W(7), .DATA_W(8), .MEM_LAT(3)) u3 (.clk(clk), .reset(reset), .bus(b3.slave));

  always #5 clk = ~clk;

  logic [7:0] mem1 [128];
  logic [7:0] mem3 [128];
  logic [7:0] rd1;
  logic [7:0] p3 [3];
  always @(posedge clk) begin
    if (b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
    rd1   <= mem1[b1.mem_addr];
    p3[0] <= mem3[b3.mem_addr];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b1.mem_rdata = rd1;
  assign b3.mem_rdata = p3[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (b1.mem_we) we_cnt++;
    if (b1.spi_ack || b1.lcl_ack) begin
      ack_cnt++;
      chk("sb_expected_ack", 32'(sb.size() > 0), 1);
      chk("sb_single_ack", 32'(b1.spi_ack & b1.lcl_ack), 0);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_port", 32'(b1.lcl_ack), 32'(e.lcl));
        if (e.rd) chk("sb_rdata", 32'(b1.lcl_ack ? b1.lcl_rdata : b1.spi_rdata), 32'(e.data));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic spi(input logic req, input logic we, input logic [6:0] a, input logic [7:0] d);
    b1.spi_req = req; b1.spi_we = we; b1.spi_addr = a; b1.spi_wdata = d;
  endtask

  task automatic lcl(input logic req, input logic we, input logic [6:0] a, input logic [7:0] d);
    b1.lcl_req = req; b1.lcl_we = we; b1.lcl_addr = a; b1.lcl_wdata = d;
  endtask

  task automatic push(input logic is_lcl, input logic rd, input logic [7:0] d);
    exp_t e;
    e.lcl = is_lcl; e.rd = rd; e.data = d;
    sb.push_back(e);
  endtask

  initial begin
    int n, w0;
    for (int i = 0; i < 128; i++) begin
      mem1[i] = 8'(i);
      mem3[i] = 8'(i);
    end
    mem1[0] = 8'hEE; mem1[1] = 8'h11; mem1[2] = 8'h22; mem3[127] = 8'h3C;
    spi(0, 0, 0, 0); lcl(0, 0, 0, 0);
    b3.spi_req = 0; b3.spi_we = 0; b3.spi_addr = 0; b3.spi_wdata = 0;
    b3.lcl_req = 0; b3.lcl_we = 0; b3.lcl_addr = 0; b3.lcl_wdata = 0;
    tick(2);
    reset = 1'b0;
    chk("rst_owner", 32'(b1.owner), 0);
    chk("rst_busy", 32'(b1.busy), 0);
    chk("rst_acks", 32'({b1.spi_ack, b1.lcl_ack}), 0);
    chk("rst_rdata", 32'({b1.spi_rdata, b1.lcl_rdata}), 0);
    chk("rst_mem", 32'({b1.mem_we, b1.mem_addr, b1.mem_wdata}), 0);

    // SPI write 0x15 <= 0xA5, then local read back
    spi(1, 1, 7'h15, 8'hA5); push(0, 0, 0);
    tick(); spi(0, 0, 0, 0);
    chk("wr_issue_we", 32'(b1.mem_we), 1);
    chk("wr_issue_addr", 32'(b1.mem_addr), 32'h15);
    chk("wr_issue_data", 32'(b1.mem_wdata), 32'hA5);
    chk("wr_issue_owner", 32'(b1.owner), 1);
    tick();
    chk("wr_done_we", 32'(b1.mem_we), 0);
    chk("wr_done_ack", 32'(b1.spi_ack), 1);
    tick();
    chk("wr_idle_busy", 32'(b1.busy), 0);
    lcl(1, 0, 7'h15, 8'h00); push(1, 1, 8'hA5);
    tick(); lcl(0, 0, 0, 0);
    chk("rd_issue_we", 32'(b1.mem_we), 0);
    chk("rd_issue_owner", 32'(b1.owner), 2);
    tick();
    chk("rd_ack_n2", 32'(b1.lcl_ack), 0);
    tick();
    chk("rd_ack_n3", 32'(b1.lcl_ack), 1);
    chk("rd_spi_rdata_kept", 32'(b1.spi_rdata), 0);
    tick();
    chk("we_pulse_count", 32'(we_cnt), 1);

    // simultaneous reads from reset-like pointer state
    spi(1, 0, 7'h01, 0); lcl(1, 0, 7'h02, 0); push(0, 1, 8'h11); push(1, 1, 8'h22);
    tick(); spi(0, 0, 0, 0);
    chk("tie_first_owner", 32'(b1.owner), 1);
    tick(2);
    chk("tie_spi_done", 32'(b1.spi_ack), 1);
    tick();
    chk("tie_no_bubble", 32'({b1.busy, b1.owner}), 32'b110);
    lcl(0, 0, 0, 0);
    tick(3);

    // both hold req for 6 write transactions
    w0 = we_cnt;
    for (int k = 0; k < 6; k++)
`ifdef SPI_FIXED_PRIORITY_EN
      push(0, 0, 0);
`else
      push(k % 2 == 1, 0, 0);
`endif
    spi(1, 1, 7'h20, 8'h61); lcl(1, 1, 7'h30, 8'h72);
    n = 0;
    for (int t = 0; t < 40 && n < 6; t++) begin
      tick();
      if (b1.spi_ack || b1.lcl_ack) n++;
      if (n == 6) begin spi(0, 0, 0, 0); lcl(0, 0, 0, 0); end
    end
    chk("rr_six_acks", 32'(n), 6);
    spi(0, 0, 0, 0); lcl(0, 0, 0, 0);
    tick(2);
    chk("rr_idle", 32'(b1.busy), 0);
    chk("rr_we_pulses", 32'(we_cnt - w0), 6);
    chk("rr_spi_mem", 32'(mem1[7'h20]), 32'h61);
`ifndef SPI_FIXED_PRIORITY_EN
    chk("rr_lcl_mem", 32'(mem1[7'h30]), 32'h72);
`endif

    // MEM_LAT=3 read of 0x7F
    b3.spi_req = 1; b3.spi_we = 0; b3.spi_addr = 7'h7F;
    for (int k = 1; k <= 5; k++) begin
      tick();
      b3.spi_req = 0;
      chk($sformatf("lat3_ack_n%0d", k), 32'(b3.spi_ack), 32'(k == 5));
    end
    chk("lat3_rdata", 32'(b3.spi_rdata), 32'h3C);
    chk("lat3_lcl_rdata", 32'(b3.lcl_rdata), 0);
    tick();

    // request fields latched at grant
    lcl(1, 0, 7'h15, 8'h00); push(1, 1, 8'hA5);
    tick(); lcl(0, 0, 7'h00, 8'h00);
    chk("latch_issue_addr", 32'(b1.mem_addr), 32'h15);
    tick();
    chk("latch_wait_addr", 32'(b1.mem_addr), 32'h15);
    tick();
    chk("latch_ack", 32'(b1.lcl_ack), 1);
    tick();

    // reset during WAIT after SPI was last granted
    spi(1, 1, 7'h40, 8'h99); push(0, 0, 0);
    tick(); spi(0, 0, 0, 0);
    tick(2);
    spi(1, 0, 7'h01, 0);
    tick(); spi(0, 0, 0, 0);
    tick();
    chk("abort_in_wait", 32'({b1.busy, b1.owner}), 32'b101);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_owner", 32'(b1.owner), 0);
    chk("abort_busy", 32'(b1.busy), 0);
    chk("abort_ack", 32'(b1.spi_ack), 0);
    chk("abort_we", 32'(b1.mem_we), 0);
    chk("abort_rdata", 32'(b1.spi_rdata), 0);
    spi(1, 0, 7'h01, 0); lcl(1, 0, 7'h02, 0); push(0, 1, 8'h11); push(1, 1, 8'h22);
    tick(); spi(0, 0, 0, 0);
    chk("post_rst_tie", 32'(b1.owner), 1);
    tick(3);
    chk("post_rst_lcl", 32'(b1.owner), 2);
    lcl(0, 0, 0, 0);
    tick(4);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_mem_arbiter.md
# spi_mem_arbiter

Two-port arbiter sharing the single-port SPI data memory between the SPI slave path and a local core requester. Each requester issues a byte read or write with a req/ack handshake. The arbiter serialises the accesses, drives the memory address/write-enable/data and returns read data. It sits between the SPI slave FSM's address/memory-enable outputs and the data memory, and replaces the direct memory write-enable connection.

## Interface
- ADDR_W, 7: memory address width (address byte minus the R/W bit)
- DATA_W, 8: data width
- MEM_LAT, 1: memory read latency in clk cycles, legal range 1..7

- clk  in  1: system clock; all logic on its rising edge
- reset  in  1: synchronous, active-high reset
- spi_req  in  1: SPI-side access request
- spi_we  in  1: 1 = write, 0 = read
- spi_addr  in  ADDR_W: SPI-side address
- spi_wdata  in  DATA_W: SPI-side write data
- spi_ack  out  1: one-cycle completion pulse
- spi_rdata  out  DATA_W: read data, valid while spi_ack is high and held afterwards
- lcl_req / lcl_we / lcl_addr / lcl_wdata / lcl_ack / lcl_rdata: local-port equivalents of the SPI signals
- mem_addr  out  ADDR_W: memory address
- mem_we  out  1: memory write enable
- mem_wdata  out  DATA_W: memory write data
- mem_rdata  in  DATA_W: memory read data
- owner  out  2: one-hot current grant ({lcl, spi}); 00 when idle
- busy  out  1: high in every state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**: sample both req inputs.
  - If neither is high, stay in IDLE.
  - If one is high, grant it.
  - If both are high, grant the requester that was not granted last (round-robin).
  - On grant, latch that requester's we/addr/wdata, set owner, and go to ISSUE.
- **ISSUE** (exactly 1 cycle):
  - mem_addr and mem_wdata come from the latch.
  - mem_we = latched we.
  - Writes go to DONE. Reads go to WAIT with the latency counter loaded to MEM_LAT-1.
- **WAIT**:
  - mem_addr is held and mem_we = 0.
  - When the counter reads 0, capture mem_rdata into the owner's rdata register and go to DONE. Otherwise decrement.
- **DONE** (1 cycle):
  - The owner's ack is high.
  - Update the last-granted pointer.
  - Arbitrate exactly as in IDLE, except the requester being acked is ignored this cycle. The next state is ISSUE (new grant) or IDLE.
- Latched request fields are immune to requester changes after grant. Deasserting req mid-transaction does not abort it, and ack still pulses.
- The non-owner's rdata and ack are never disturbed.
- Reset values:
  - State IDLE; owner 00; busy 0; both acks 0; both rdata 0.
  - mem_addr 0, mem_we 0, mem_wdata 0.
  - Last-granted = lcl, so SPI wins the first tie.
- Reset mid-transaction: the next edge forces IDLE. mem_we drops, no ack is issued and the transaction is lost.

## Timing
- Request sampled high in IDLE at cycle N:
  - ISSUE in N+1.
  - Write: memory written at the end of N+1; ack high in N+2.
  - Read: mem_rdata captured at the end of N+1+MEM_LAT; ack and rdata valid in N+2+MEM_LAT. With MEM_LAT=1, read ack is in N+3.
- Back-to-back: a grant made in DONE puts ISSUE in the very next cycle. There are no idle bubbles between alternating requesters.
- A requester holding req high continuously gets at most every other slot while the other port is also requesting.
- mem_we is high for exactly one cycle per write and never during reads, WAIT, DONE or IDLE.

## Configuration
- SPI_FIXED_PRIORITY_EN
  - Defined: ties always go to SPI, and the last-granted pointer is unused. The local port can starve. This suits SPI's hard per-bit deadline in its LOAD phase.
  - Undefined (default): two-way round-robin as described above.

## Structure
- Shared package spi_mem_pkg holds:
  - State enum (IDLE/ISSUE/WAIT/DONE)
  - Owner one-hot constants OWN_NONE/OWN_SPI/OWN_LCL
  - Default ADDR_W/DATA_W values shared with the SPI slave FSM and the memory
- One sub-module, rr_pick2, is natural:
  - Inputs: two requests, last-granted pointer, an exclude mask.
  - Output: one-hot grant.
  - Purely combinational. The macro selects fixed or round-robin logic inside it.

## Test plan
- Single SPI write (addr 0x15, data 0xA5), then local read of 0x15 → mem_we high only in cycle N+1; lcl_ack in read N+3 with lcl_rdata = 0xA5.
- Both ports request in the same cycle from reset, both reading (addr 0x01 and 0x02) → SPI granted first, local granted in the SPI DONE cycle; owner sequence 01, 10 with no IDLE between.
- Both ports hold req continuously for 6 transactions → grants strictly alternate SPI/LCL; with SPI_FIXED_PRIORITY_EN, all 6 grants go to SPI.
- MEM_LAT=3, SPI read of 0x7F holding 0x3C → spi_ack exactly in N+5 with spi_rdata = 0x3C; lcl_rdata unchanged.
- Requester drops req one cycle after grant, with lcl_addr changed to 0x00 → transaction completes on the latched address and ack still pulses.
- reset asserted during WAIT → IDLE next cycle; no ack, owner 00, mem_we 0; the next tie is won by SPI.
